serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares one `full_adder` cell across all bit positions of a WIDTH-bit addition. It accepts an operand pair over a valid/ready handshake and sequences the cell LSB-first for one bit per clock, holding the running carry in a flip-flop. It presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between operand producers and result consumers wherever area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell reused LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// in_ready is purely a function of state, and a raised out_valid holds its data
// stable until out_ready completes the transfer.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum, fa_carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             cmsb_q, cmsb_d;
`endif

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    cmsb_d  = cmsb_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum fills from the top so bit 0 lands in sum[0] after WIDTH shifts.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          cmsb_d  = carry_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q  <= cmsb_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum_out   = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = cmsb_q ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl at WIDTH=8; ovf checks compile in with SERIAL_ADD_OVF_EN.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issues one operation; leaves the DUT in DONE when hold is set
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic hold, output logic [W-1:0] s, output logic co,
                        output logic ov, output int lat, output int busy_n);
    int guard;
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    lat = 0; busy_n = 0; guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    s  = sum_out;
    co = cout;
`ifdef SERIAL_ADD_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", sum_out); end
    checks++;
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co, ov; int lat, bn;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, s, co, ov, lat, bn);
    checks++;
    if (s !== 8'h96) begin errors++; $display("FAIL basic_sum got %h exp 96", s); end
    checks++;
    if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", co); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d edges after accept exp 8", lat); end
    checks++;
    if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bn); end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] s; logic co, ov; int lat, bn;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01 got %h exp 100", {co, s}); end
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_00_cin got %h exp 100", {co, s}); end
    run_op(8'hA5, 8'hC3, 1'b1, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({co, s} !== 9'h169) begin errors++; $display("FAIL carry_a5_c3_cin got %h exp 169", {co, s}); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s; logic co, ov; int lat, bn;
    logic stable_ok, ready_low_ok;
    run_op(8'h12, 8'h34, 1'b0, 1'b1, s, co, ov, lat, bn);
    checks++;
    if (s !== 8'h46 || co !== 1'b0) begin errors++; $display("FAIL bp_result got %b_%h exp 0_46", co, s); end
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b1; in_valid = 1'b1;
    stable_ok = 1'b1; ready_low_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || sum_out !== 8'h46 || cout !== 1'b0) stable_ok = 1'b0;
      if (in_ready !== 1'b0 || busy !== 1'b0) ready_low_ok = 1'b0;
    end
    checks++;
    if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_stable got last %b_%h valid=%b exp 0_46 valid=1", cout, sum_out, out_valid); end
    checks++;
    if (ready_low_ok !== 1'b1) begin errors++; $display("FAIL bp_in_ready_low got in_ready=%b busy=%b exp 0 0", in_ready, busy); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic co, ov; int lat, bn;
    a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state got in_ready=%b busy=%b out_valid=%b exp 1 0 0", in_ready, busy, out_valid);
    end
    checks++;
    if (sum_out !== 8'h00 || cout !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %b_%h exp 0_00", cout, sum_out); end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({co, s} !== 9'h002) begin errors++; $display("FAIL midrst_fresh got %h exp 002", {co, s}); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    int n_acc, n_res;
    logic acc_now;
    logic [W:0] exp_v;
    n_acc = 0; n_res = 0;
    exp_q.push_back(9'h096);
    exp_q.push_back(9'h100);
    a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc_now = in_valid & in_ready;
      if (out_valid) begin
        n_res++;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          checks++;
          if ({cout, sum_out} !== exp_v) begin
            errors++; $display("FAIL b2b_result%0d got %h exp %h", n_res, {cout, sum_out}, exp_v);
          end
        end
      end
      tick();
      if (acc_now) begin
        if (n_acc < 2) acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin a_in = 8'hFF; b_in = 8'h01; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (n_acc !== 2) begin errors++; $display("FAIL b2b_accept_count got %0d exp 2", n_acc); end
    else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 10) begin
        errors++; $display("FAIL b2b_spacing got %0d exp 10", acc_cyc[1] - acc_cyc[0]);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_results_left got %0d exp 0", exp_q.size()); end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] s; logic co, ov; int lat, bn;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({ov, co, s} !== 10'h280) begin errors++; $display("FAIL ovf_7f_01 got ovf=%b cout=%b sum=%h exp 1 0 80", ov, co, s); end
    run_op(8'h80, 8'h80, 1'b0, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({ov, co, s} !== 10'h300) begin errors++; $display("FAIL ovf_80_80 got ovf=%b cout=%b sum=%h exp 1 1 00", ov, co, s); end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, s, co, ov, lat, bn);
    checks++;
    if ({ov, co, s} !== 10'h030) begin errors++; $display("FAIL ovf_10_20 got ovf=%b cout=%b sum=%h exp 0 0 30", ov, co, s); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
